// File: rtl/ringuart_tx_if.sv
// Bus-side register interface of the buffered UART transmitter:
// a status read port and a byte write port with a wait stall.
interface ringuart_tx_if;
    logic        reg_state_re;
    logic [31:0] reg_state_do;
    logic        reg_state_wait;
    logic        reg_dat_we;
    logic [31:0] reg_dat_di;
    logic        reg_dat_wait;

    modport master (
        output reg_state_re, reg_dat_we, reg_dat_di,
        input  reg_state_do, reg_state_wait, reg_dat_wait
    );

    modport slave (
        input  reg_state_re, reg_dat_we, reg_dat_di,
        output reg_state_do, reg_state_wait, reg_dat_wait
    );
endinterface

// File: rtl/ringuart_tx.sv
// Buffered 8N1 UART transmitter: CPU byte writes are queued in a ring and
// shifted out LSB first. A full ring stalls the writer instead of dropping bytes.
module ringuart_tx #(
    parameter int UART_CLK     = 12000000,
    parameter int BAUD_RATE    = 115200,
    parameter int RING_SIZE_TX = 2
) (
    input  logic         clk,
    input  logic         resetn,
    output logic         ser_tx,
    ringuart_tx_if.slave bus
);
    localparam int UART_DIV = UART_CLK / BAUD_RATE;
    localparam int DEPTH    = 2 ** RING_SIZE_TX;
    localparam int CW       = $clog2(UART_DIV);
    localparam logic [CW-1:0]         BAUD_LAST = CW'(UART_DIV - 1);
    localparam logic [RING_SIZE_TX:0] FULL_CNT  = {1'b1, {RING_SIZE_TX{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                state;
    logic [RING_SIZE_TX:0] head;
    logic [RING_SIZE_TX:0] tail;
    logic [RING_SIZE_TX:0] count;
    logic [CW-1:0]         baud_cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shift;
    logic [7:0]            ring [DEPTH];
    logic                  empty;
    logic                  full;
    logic                  busy;
    logic                  baud_end;
    logic                  push;
    logic                  pop;
    logic                  unused_bus;

    assign count    = tail - head;
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign busy     = (state != S_IDLE) || !empty;
    assign baud_end = (baud_cnt == BAUD_LAST);

    // Full is taken from the current count, so a same-cycle pop never admits a stalled write.
    assign push = bus.reg_dat_we && !full;
    assign pop  = !empty && ((state == S_IDLE) || (state == S_STOP && baud_end));

    assign bus.reg_dat_wait   = bus.reg_dat_we && full;
    assign bus.reg_state_wait = 1'b0;
    assign bus.reg_state_do   = {8'(count), 8'(tail[RING_SIZE_TX-1:0]),
                                 8'(head[RING_SIZE_TX-1:0]), 5'b0, empty, full, busy};

    assign unused_bus = &{1'b0, bus.reg_state_re, bus.reg_dat_di[31:8]};

    // Ring storage is deliberately left out of reset; only the pointers matter.
    always_ff @(posedge clk) begin
        if (push)
            ring[tail[RING_SIZE_TX-1:0]] <= bus.reg_dat_di[7:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            head     <= '0;
            tail     <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            ser_tx   <= 1'b1;
        end else begin
            if (push)
                tail <= tail + 1'b1;

            if (pop) begin
                head     <= head + 1'b1;
                shift    <= ring[head[RING_SIZE_TX-1:0]];
                baud_cnt <= '0;
                state    <= S_START;
            end else begin
                case (state)
                    S_IDLE: baud_cnt <= '0;
                    S_START: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= S_DATA;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            shift    <= shift >> 1;
                            if (bit_idx == 3'd7)
                                state <= S_STOP;
                            else
                                bit_idx <= bit_idx + 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            state    <= S_IDLE;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end

            // Line level follows the state one cycle later, so each bit keeps full width.
            case (state)
                S_START: ser_tx <= 1'b0;
                S_DATA:  ser_tx <= shift[0];
                default: ser_tx <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_ringuart_tx.sv
// Self-checking bench for ringuart_tx: table-driven single frames, a line
// monitor scoreboard checking every cycle of every frame, and corner sequences.
module tb_ringuart_tx;
    localparam int DIV = 104;

    logic clk;
    logic resetn;
    logic ser_tx;

    ringuart_tx_if bus ();

    ringuart_tx #(
        .UART_CLK    (12000000),
        .BAUD_RATE   (115200),
        .RING_SIZE_TX(2)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .ser_tx(ser_tx),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int frames_seen = 0;
    int acc_cyc = 0;
    bit mon_en = 1'b1;
    logic [7:0] exp_q[$];
    int start_q[$];

    typedef struct {
        logic [31:0] di;
        logic [31:0] st_push;
        logic [31:0] st_pop;
        logic [31:0] st_done;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wr(input logic [31:0] d, output int stalls);
        stalls = 0;
        bus.reg_dat_we = 1'b1;
        bus.reg_dat_di = d;
        #1;
        while (bus.reg_dat_wait === 1'b1 && stalls < 3000) begin
            @(posedge clk); #2;
            stalls++;
        end
        if (stalls >= 3000) chk("write_timeout", 32'(stalls), 32'd0);
        @(posedge clk); #1;
        bus.reg_dat_we = 1'b0;
        acc_cyc = cyc;
        exp_q.push_back(d[7:0]);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.reg_state_do[0] !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // Line monitor: every cycle of a frame must match the scoreboard's next byte.
    initial begin : monitor
        logic [7:0] eb;
        logic [9:0] lv;
        int bad;
        bit aborted;
        forever begin
            @(posedge clk); #1;
            if (mon_en && ser_tx === 1'b0) begin
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                    eb = 8'h00;
                end else begin
                    eb = exp_q.pop_front();
                end
                lv = {1'b1, eb, 1'b0};
                bad = 0;
                aborted = 1'b0;
                for (int i = 0; i < 10 * DIV; i++) begin
                    if (i > 0) begin @(posedge clk); #1; end
                    if (!mon_en) begin aborted = 1'b1; break; end
                    if (ser_tx !== lv[i / DIV]) bad++;
                end
                if (!aborted) begin
                    chk($sformatf("frame_wave_%02h_bad_cycles", eb), 32'(bad), 32'd0);
                    frames_seen++;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int st, hi_cnt, bad_st, bad_w, s0, s1, exp_frames;
        logic [31:0] d6;

        vt[0] = '{32'hDEADBE41, 32'h01010001, 32'h00010105, 32'h00010104};
        vt[1] = '{32'h000000A5, 32'h01020101, 32'h00020205, 32'h00020204};
        vt[2] = '{32'h12345600, 32'h01030201, 32'h00030305, 32'h00030304};
        vt[3] = '{32'hFFFFFFFF, 32'h01000301, 32'h00000005, 32'h00000004};

        resetn = 1'b0;
        bus.reg_state_re = 1'b0;
        bus.reg_dat_we = 1'b0;
        bus.reg_dat_di = '0;
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk); #1;

        // Reset values and a long idle stretch
        chk("reset_status", bus.reg_state_do, 32'h00000004);
        chk("reset_dat_wait", 32'(bus.reg_dat_wait), 32'd0);
        chk("reset_state_wait", 32'(bus.reg_state_wait), 32'd0);
        hi_cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (ser_tx !== 1'b1) hi_cnt++;
        end
        chk("idle_line_low_cycles", 32'(hi_cnt), 32'd0);
        chk("idle_status", bus.reg_state_do, 32'h00000004);

        // Table: single frames from idle, pointers wrap on the last row
        exp_frames = 0;
        for (int r = 0; r < 4; r++) begin
            start_q.delete();
            wr(vt[r].di, st);
            chk("row_stalls", 32'(st), 32'd0);
            chk($sformatf("row%0d_status_push", r), bus.reg_state_do, vt[r].st_push);
            @(posedge clk); #1;
            chk($sformatf("row%0d_status_pop", r), bus.reg_state_do, vt[r].st_pop);
            chk($sformatf("row%0d_line_high_after_pop", r), 32'(ser_tx), 32'd1);
            wait_idle(1300);
            exp_frames++;
            chk($sformatf("row%0d_frames_seen", r), 32'(frames_seen), 32'(exp_frames));
            chk($sformatf("row%0d_status_done", r), bus.reg_state_do, vt[r].st_done);
            if (start_q.size() > 0)
                chk($sformatf("row%0d_start_latency", r), 32'(start_q[0] - acc_cyc), 32'd2);
            else
                chk($sformatf("row%0d_start_seen", r), 32'd0, 32'd1);
        end

        // Burst of five fills the ring, the sixth stalls until the next pop
        start_q.delete();
        for (int i = 0; i < 5; i++) begin
            wr({24'hABCDEF, 8'(8'h11 * (i + 1))}, st);
            chk($sformatf("burst%0d_stalls", i), 32'(st), 32'd0);
        end
        chk("burst_full_status", bus.reg_state_do, 32'h04010103);
        d6 = 32'h00000066;
        wr(d6, st);
        chk("sixth_write_stalls", 32'(st), 32'd1037);
        wait_idle(7000);
        exp_frames += 6;
        chk("burst_frames_seen", 32'(frames_seen), 32'(exp_frames));
        chk("burst_status_done", bus.reg_state_do, 32'h00020204);
        chk("burst_frame_count", 32'(start_q.size()), 32'd6);
        for (int i = 1; i < start_q.size(); i++)
            chk($sformatf("burst_gap%0d", i), 32'(start_q[i] - start_q[i-1]), 32'(10 * DIV));
        if (start_q.size() == 6)
            chk("burst_total_span", 32'(start_q[5] - start_q[0] + 10 * DIV), 32'd6240);

        // 0x00 then 0xFF back to back: no idle gap between frames
        start_q.delete();
        wr(32'h00000000, st);
        wr(32'h000000FF, st);
        wait_idle(2500);
        exp_frames += 2;
        chk("pair_frames_seen", 32'(frames_seen), 32'(exp_frames));
        s0 = (start_q.size() > 0) ? start_q[0] : 0;
        s1 = (start_q.size() > 1) ? start_q[1] : 0;
        chk("pair_start_gap", 32'(s1 - s0), 32'd1040);
        chk("pair_status_done", bus.reg_state_do, 32'h00000004);

        // Asynchronous reset during data bit 3 of a zero byte with two more queued
        mon_en = 1'b0;
        wr(32'h00000000, st);
        wr(32'h00000000, st);
        wr(32'h00000000, st);
        repeat (450) @(posedge clk);
        #3;
        chk("pre_reset_line_low", 32'(ser_tx), 32'd0);
        chk("pre_reset_count", 32'(bus.reg_state_do[31:24]), 32'd2);
        resetn = 1'b0;
        #1;
        chk("reset_line_high_now", 32'(ser_tx), 32'd1);
        chk("in_reset_status", bus.reg_state_do, 32'h00000004);
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;
        exp_q.delete();
        start_q.delete();
        hi_cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            if (ser_tx !== 1'b1) hi_cnt++;
        end
        chk("post_reset_line_low_cycles", 32'(hi_cnt), 32'd0);
        chk("post_reset_status", bus.reg_state_do, 32'h00000004);
        mon_en = 1'b1;

        // Status reads during a frame have no side effects
        wr(32'h0000003C, st);
        @(posedge clk); #1;
        bad_st = 0;
        bad_w = 0;
        for (int i = 0; i < 900; i++) begin
            bus.reg_state_re = ~bus.reg_state_re;
            @(posedge clk); #1;
            if (bus.reg_state_do !== 32'h00010105) bad_st++;
            if (bus.reg_state_wait !== 1'b0) bad_w++;
        end
        bus.reg_state_re = 1'b0;
        chk("read_status_changed_cycles", 32'(bad_st), 32'd0);
        chk("read_state_wait_cycles", 32'(bad_w), 32'd0);
        wait_idle(500);
        exp_frames++;
        chk("read_frames_seen", 32'(frames_seen), 32'(exp_frames));
        chk("read_status_done", bus.reg_state_do, 32'h00010104);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ringuart_tx.md
# ringuart_tx

Buffered UART transmitter for the picorv32 memory-mapped bus, the transmit-side counterpart to the ring receive path. CPU byte writes are queued in a power-of-two ring buffer and serialized on `ser_tx` as 8N1 frames by an internal baud generator and shift FSM. A status word reports busy, full, empty, occupancy and ring pointers. A full ring stalls the bus through the wait output, so no bytes are dropped.

## Interface
Parameters:
- `UART_CLK`, 12000000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate; bit period `UART_DIV = UART_CLK / BAUD_RATE` cycles (integer division, must be ≥ 2).
- `RING_SIZE_TX`, 2: log2 of ring depth; legal range 1..7; depth `2**RING_SIZE_TX`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  reset; asynchronous, active-low.
- `ser_tx`  out  1  serial output; idles high.
- `reg_state_re`  in  1  status read strobe; no side effects.
- `reg_state_do`  out  32  status word, combinational from registers.
- `reg_state_wait`  out  1  tied 0.
- `reg_dat_we`  in  1  data write strobe; pushes `reg_dat_di[7:0]`.
- `reg_dat_di`  in  32  write data; bits [31:8] ignored.
- `reg_dat_wait`  out  1  `reg_dat_we && full`; the bus holds the write until the wait output drops.

## Operation
- Ring: byte array, `head` (read) and `tail` (write) pointers of `RING_SIZE_TX+1` bits, including a wrap bit. `count = tail - head`, modulo. `empty = (count == 0)`. `full = (count == 2**RING_SIZE_TX)`.
- Push: `reg_dat_we && !full` writes `reg_dat_di[7:0]` to `ring[tail]` and increments `tail`. If the ring is full, nothing is written and the wait output is high. `full` is evaluated on the current count, so a pop in the same cycle does not admit the write.
- Pop: the FSM copies `ring[head]` into an 8-bit shift register and increments `head`. Pop and push in the same cycle are both performed, and `count` is unchanged.
- FSM states:
  - IDLE: `ser_tx=1`. If not empty: pop, clear the baud counter, go to START.
  - START: `ser_tx=0` for `UART_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `ser_tx=shift[0]`, LSB first, for `UART_DIV` cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `ser_tx=1` for `UART_DIV` cycles. At the end: if not empty, pop and go to START with no idle gap; else go to IDLE.
- Baud counter runs 0..`UART_DIV-1` and is cleared on every pop. A bit boundary occurs when the count equals `UART_DIV-1`.
- `ser_tx` is a registered output.
- `busy = (state != IDLE) || !empty`.
- `reg_state_do` fields:
  - [31:24] `count`, zero-extended.
  - [23:16] `tail[RING_SIZE_TX-1:0]`, zero-extended.
  - [15:8] `head[RING_SIZE_TX-1:0]`, zero-extended.
  - [7:0] `{5'b0, empty, full, busy}`.
- Reset (asynchronous, any time including mid-frame): `ser_tx=1` immediately; FSM goes to IDLE; `head`, `tail`, baud counter and bit index go to 0; `reg_dat_wait=0`. Ring contents are not cleared. The in-flight frame is truncated, and queued bytes are discarded.

## Timing
- Reset values: `ser_tx=1`, `reg_state_do=0x00000004`, `reg_dat_wait=0`, `reg_state_wait=0`.
- Write accepted at edge N into an idle, empty block: pop at edge N+1. `ser_tx` falls after edge N+2 (registered) and stays low for `UART_DIV` cycles.
- Frame length: exactly `10*UART_DIV` cycles. Consecutive queued frames are contiguous.
- `busy` clears on the edge the FSM enters IDLE with the ring empty.
- With `full` high, the first stalled write is accepted on the edge after the next pop.

## Test plan
Defaults give `UART_DIV=104` and depth 4.
- Reset, then idle for 2000 cycles -> `ser_tx=1` throughout; `reg_state_do=0x00000004`; `reg_dat_wait=0`.
- Write `0xDEADBE41` -> frame line levels 0,1,0,0,0,0,0,1,0,1 (start, bits 0–7 of 0x41, stop), each level 104 cycles. Afterwards `reg_state_do=0x00010104`.
- Write 5 bytes on consecutive cycles, then a 6th -> first 5 accepted with no wait; status shows `full`, `count=4`. 6th write: `reg_dat_wait=1` until byte 1 pops at the end of frame 0, then accepted. All 6 bytes transmitted in order, 6240 cycles contiguous.
- Queue 0x00 and 0xFF -> second start bit begins exactly 1040 cycles after the first; no extra idle cycles.
- Assert `resetn=0` mid-data-bit of a frame with 2 bytes queued -> `ser_tx=1` in the same cycle. After release: status `0x00000004`, no further transmission.
- Pulse `reg_state_re` repeatedly during a frame -> pointers, `count` and the `ser_tx` waveform are unchanged; `reg_state_wait=0`.
